// File: rtl/tt_um_dantecpp_vga_montecarlo_pi_calculator_core.sv
// Monte Carlo pi estimator with a 640x480 VGA readout of the inside count as a row of 16 cells.
// Define PI_CIRCLE_BG_EN to paint the quarter-circle sampling domain as a dim red background.
module tt_um_dantecpp_vga_montecarlo_pi_calculator_core #(
    parameter int unsigned LOG_N  = 22,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned CELL_Y = 224
) (
`ifdef GL_TEST
    inout  wire        VPWR,
    inout  wire        VGND,
`endif
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    localparam int unsigned NW = LOG_N + 1;
    localparam logic [NW-1:0] N_TARGET  = {1'b1, {LOG_N{1'b0}}};
    localparam logic [NW-1:0] CNT_ONE   = {{LOG_N{1'b0}}, 1'b1};
    localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0]   LFSR_SEED = 32'hACE1_ACE1;

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd752;
    localparam logic [9:0] CELL_X0  = 10'd64;
    localparam logic [9:0] CELL_X1  = 10'd576;
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] CELL_Y0  = 10'(CELL_Y);
    localparam logic [9:0] CELL_Y1  = 10'(CELL_Y + 32);

    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        return {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // 255^2 + 255^2 < 2^17, so the 17-bit sum never overflows.
    function automatic logic in_quarter_circle(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [16:0] sq_sum;
        xx     = {8'h00, x} * {8'h00, x};
        yy     = {8'h00, y} * {8'h00, y};
        sq_sum = {1'b0, xx} + {1'b0, yy};
        return ~sq_sum[16];
    endfunction

    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] m_q, m_d;
    logic          done_q, done_d;
    logic [7:0]    uo_q, uo_d;

    logic          pause_s;
    logic          restart_s;
    logic          sample_s;
    logic          inside_s;
    logic          visible_s;
    logic          in_cell_s;
    logic          cell_bit_s;
    logic          hsync_s;
    logic          vsync_s;
    logic [9:0]    cell_off_s;
    logic [3:0]    cell_idx_s;
    logic [15:0]   cell_bits_s;
    logic [LOG_N+15:0] m_ext_s;
    logic          r1_s, g1_s, b1_s, r0_s, g0_s, b0_s;
    logic          unused_s;

    assign pause_s   = ui_in[0];
    assign restart_s = ui_in[1];
    assign sample_s  = ~pause_s & ~restart_s & ~done_q;
    assign inside_s  = in_quarter_circle(lfsr_q[7:0], lfsr_q[23:16]);

    // Beam position: h wraps every 800 clocks and carries into v.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 10'd0;
            if (v_q == V_LAST) begin
                v_d = 10'd0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    // Sampler: restart beats pause, and restart leaves the LFSR where it is.
    always_comb begin
        lfsr_d = lfsr_q;
        n_d    = n_q;
        m_d    = m_q;
        done_d = done_q;
        if (restart_s) begin
            n_d    = {NW{1'b0}};
            m_d    = {NW{1'b0}};
            done_d = 1'b0;
        end else if (sample_s) begin
            lfsr_d = lfsr_step(lfsr_q);
            n_d    = n_q + CNT_ONE;
            m_d    = m_q + {{LOG_N{1'b0}}, inside_s};
            done_d = (n_d == N_TARGET);
        end else begin
            done_d = done_q;
        end
    end

    // Cell i shows M[LOG_N-1-i]; positions below bit 0 read as zero.
    assign m_ext_s     = {m_q[LOG_N-1:0], 16'h0000};
    assign cell_bits_s = m_ext_s[LOG_N+15 -: 16];
    assign cell_off_s  = h_q - CELL_X0;
    assign cell_idx_s  = cell_off_s[8:5];
    assign cell_bit_s  = cell_bits_s[4'd15 - cell_idx_s];

    assign visible_s = (h_q < H_VIS) && (v_q < V_VIS_L);
    assign in_cell_s = (v_q >= CELL_Y0) && (v_q < CELL_Y1) && (h_q >= CELL_X0) && (h_q < CELL_X1);
    assign hsync_s   = ~((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_s   = ~((v_q >= VS_START) && (v_q < VS_END));

`ifdef PI_CIRCLE_BG_EN
    logic [9:0]  circ_dy_s;
    logic [18:0] circ_r2_s;
    logic        bg_red_s;

    // Quarter circle of radius 480 anchored at the bottom-left visible pixel.
    always_comb begin
        circ_dy_s = V_VIS_L - 10'd1 - v_q;
        circ_r2_s = ({9'd0, h_q} * {9'd0, h_q}) + ({9'd0, circ_dy_s} * {9'd0, circ_dy_s});
        bg_red_s  = (h_q < 10'd480) && (v_q < V_VIS_L) && (circ_r2_s < 19'd230400);
    end
`else
    logic bg_red_s;
    assign bg_red_s = 1'b0;
`endif

    // Pixel colour: cells over background, everything dark outside the visible area.
    always_comb begin
        r1_s = 1'b0;
        g1_s = 1'b0;
        b1_s = 1'b0;
        r0_s = 1'b0;
        g0_s = 1'b0;
        b0_s = 1'b0;
        if (visible_s) begin
            if (in_cell_s) begin
                if (cell_bit_s) begin
                    if (done_q) begin
                        g1_s = 1'b1;
                        g0_s = 1'b1;
                    end else begin
                        r1_s = 1'b1;
                        g1_s = 1'b1;
                        b1_s = 1'b1;
                        r0_s = 1'b1;
                        g0_s = 1'b1;
                        b0_s = 1'b1;
                    end
                end else begin
                    b0_s = 1'b1;
                end
            end else begin
                r0_s = bg_red_s;
            end
        end else begin
            r0_s = 1'b0;
        end
        uo_d = {hsync_s, b0_s, g0_s, r0_s, vsync_s, b1_s, g1_s, r1_s};
    end

    // State registers; rst_n is active high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            h_q    <= 10'd0;
            v_q    <= 10'd0;
            lfsr_q <= LFSR_SEED;
            n_q    <= {NW{1'b0}};
            m_q    <= {NW{1'b0}};
            done_q <= 1'b0;
            uo_q   <= 8'h88;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            lfsr_q <= lfsr_d;
            n_q    <= n_d;
            m_q    <= m_d;
            done_q <= done_d;
            uo_q   <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = m_q[LOG_N-1 -: 8];
    assign uio_oe  = 8'hFF;

    assign unused_s = ^{uio_in, ena, ui_in[7:2], m_q[LOG_N], m_ext_s[LOG_N-1:0],
                        cell_off_s[9], cell_off_s[4:0]};

endmodule

// File: tb/tb_tt_um_dantecpp_vga_montecarlo_pi_calculator_core.sv
// Scoreboard bench: a cycle model predicts uo_out/uio_out every clock; expectations are queued and popped on the falling edge.
module tb_tt_um_dantecpp_vga_montecarlo_pi_calculator_core;

    localparam int LOG_N  = 14;
    localparam int VV     = 40;
    localparam int VF     = 4;
    localparam int VS     = 2;
    localparam int VB     = 4;
    localparam int CY     = 8;
    localparam int VT     = VV + VF + VS + VB;
    localparam int FRAME  = 800 * VT;
    localparam int NW     = LOG_N + 1;
    localparam logic [NW-1:0] TARGET = {1'b1, {LOG_N{1'b0}}};

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    tt_um_dantecpp_vga_montecarlo_pi_calculator_core #(
        .LOG_N(LOG_N), .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CELL_Y(CY)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] sb_uo[$];
    logic [7:0] sb_uio[$];

    int          mh, mv;
    logic [NW-1:0] mn, mm;
    logic        mdone;
    logic [31:0] mlfsr;

    int   edges      = 0;
    int   first_fall = 0;
    int   hs_low     = 0;
    int   vs_low     = 0;
    int   green_cnt  = 0;
    int   white_cnt  = 0;
    logic hs_prev    = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] model_pixel(input int h, input int v, input logic [NW-1:0] m,
                                               input logic done);
        logic hs, vs, r1, g1, b1, r0, g0, b0;
        int   idx;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        {r1, g1, b1, r0, g0, b0} = 6'b000000;
        if (h < 640 && v < VV) begin
            if (v >= CY && v < CY + 32 && h >= 64 && h < 576) begin
                idx = LOG_N - 1 - (h - 64) / 32;
                if (idx >= 0 && m[idx]) begin
                    if (done) {g1, g0} = 2'b11;
                    else {r1, g1, b1, r0, g0, b0} = 6'b111111;
                end else begin
                    b0 = 1'b1;
                end
            end else begin
`ifdef PI_CIRCLE_BG_EN
                r0 = (h < 480) && ((h * h + (VV - 1 - v) * (VV - 1 - v)) < 230400);
`else
                r0 = 1'b0;
`endif
            end
        end
        return {hs, b0, g0, r0, vs, b1, g1, r1};
    endfunction

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // One clock: model predicts at the rising edge, DUT is compared at the falling edge.
    task automatic tick();
        logic [7:0]    x, y, got_uo, exp_uo, exp_uio;
        logic [NW-1:0] tmp;
        logic          hs;
        @(posedge clk);
        if (rst_n) begin
            mh = 0; mv = 0; mn = '0; mm = '0; mdone = 1'b0; mlfsr = 32'hACE1_ACE1;
            sb_uo.push_back(8'h88);
            sb_uio.push_back(8'h00);
        end else begin
            sb_uo.push_back(model_pixel(mh, mv, mm, mdone));
            if (mh == 799) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            if (ui_in[1]) begin
                mn = '0; mm = '0; mdone = 1'b0;
            end else if (!ui_in[0] && !mdone) begin
                x = mlfsr[7:0];
                y = mlfsr[23:16];
                if (int'(x) * int'(x) + int'(y) * int'(y) < 65536) mm = mm + 1'b1;
                mn = mn + 1'b1;
                if (mn == TARGET) mdone = 1'b1;
                mlfsr = model_lfsr(mlfsr);
            end
            tmp = mm >> (LOG_N - 8);
            sb_uio.push_back(tmp[7:0]);
            edges++;
        end
        @(negedge clk);
        if (sb_uo.size() == 0 || sb_uio.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            exp_uo  = sb_uo.pop_front();
            exp_uio = sb_uio.pop_front();
            got_uo  = uo_out;
            check_eq("uo_out", got_uo, exp_uo);
            check_eq("uio_out", uio_out, exp_uio);
        end
        if (!rst_n) begin
            hs = uo_out[7];
            if (hs_prev && !hs && first_fall == 0) first_fall = edges;
            hs_prev = hs;
            if (!hs) hs_low++;
            if (edges <= FRAME && !uo_out[3]) vs_low++;
            if (edges % 800 == 0 && edges <= FRAME) begin
                check_eq("hsync_low_per_line", hs_low, 96);
                hs_low = 0;
            end
            if (edges == FRAME) check_eq("vsync_low_per_frame", vs_low, 1600);
            if (uo_out == 8'hAA) green_cnt++;
            if (uo_out == 8'hFF && edges > 48000) white_cnt++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [7:0]    saved_uio;
    logic [NW-1:0] saved_tmp;

    initial begin
        rst_n  = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        run(5);
        check_eq("rst_uo_out", uo_out, 8'h88);
        check_eq("rst_uio_out", uio_out, 8'h00);
        check_eq("rst_uio_oe", uio_oe, 8'hFF);

        rst_n = 1'b0;
        run(3000);
        saved_tmp = mm >> (LOG_N - 8);
        saved_uio = saved_tmp[7:0];
        ui_in = 8'h01;
        run(1000);
        ui_in = 8'h00;
        check_eq("pause_hold", uio_out, saved_uio);
        run(2000);
        check_eq("pause_resume", uio_out > saved_uio, 1);

        run(48000 - edges);
        check_eq("done_pi_range", (uio_out >= 8'd196) && (uio_out <= 8'd207), 1);
        check_eq("done_cells_green", green_cnt > 0, 1);
        check_eq("uio_oe_const", uio_oe, 8'hFF);

        ui_in = 8'h02;
        tick();
        ui_in = 8'h00;
        check_eq("restart_clear", uio_out, 8'h00);
        run(2000);
        check_eq("restart_counting", uio_out > 8'h00, 1);
        check_eq("restart_cells_white", white_cnt > 0, 1);

        check_eq("hsync_first_fall", first_fall, 657);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
